// File: rtl/la_pkg.sv
// -----------------------------------------------------------------------------
// la_pkg
// Shared definitions for the logic-analyzer capture path: default sample and
// capture-RAM widths (also used by the capture RAM and the UART framing), the
// capture_controller state encoding, and a small state-decode helper.
// No ports.
// -----------------------------------------------------------------------------
package la_pkg;

  // Default widths for the analyzer build.
  localparam int LA_DATA_W = 12;
  localparam int LA_ADDR_W = 9;

  // Controller state encoding. Plain constants keep the encoding visible
  // to older tools and waveform viewers.
  typedef logic [3:0] la_state_t;

  localparam la_state_t ST_IDLE      = 4'd0;
  localparam la_state_t ST_PRE       = 4'd1;
  localparam la_state_t ST_ARMED     = 4'd2;
  localparam la_state_t ST_POST      = 4'd3;
  localparam la_state_t ST_XFER_RD   = 4'd4;
  localparam la_state_t ST_XFER_WAIT = 4'd5;
  localparam la_state_t ST_XFER_SEND = 4'd6;
  localparam la_state_t ST_XFER_GAP  = 4'd7;
  localparam la_state_t ST_DONE      = 4'd8;

  // Busy covers every state except the two resting states.
  function automatic logic la_is_busy(input la_state_t st);
    return (st != ST_IDLE) && (st != ST_DONE);
  endfunction

endpackage

// File: rtl/capture_controller_if.sv
// -----------------------------------------------------------------------------
// capture_controller_if
// Bundles the capture-RAM ports and the UART transmit handshake of the
// capture controller.
//   master : controller side (drives RAM write/read address, UART data/strobe)
//   slave  : RAM + UART side (returns read data and UART ready)
// Signals:
//   o_write_data/o_write_address/o_write_en : RAM write port
//   o_read_address / i_read_data            : RAM read port, 1-cycle latency
//   i_tx_ready / o_tx_data / o_tx_en        : UART idle flag, word, send pulse
// -----------------------------------------------------------------------------
interface capture_controller_if
  import la_pkg::*;
#(
  parameter int DATA_W = LA_DATA_W,
  parameter int ADDR_W = LA_ADDR_W
);

  logic [DATA_W-1:0] o_write_data;
  logic [ADDR_W-1:0] o_write_address;
  logic              o_write_en;
  logic [ADDR_W-1:0] o_read_address;
  logic [DATA_W-1:0] i_read_data;
  logic              i_tx_ready;
  logic [DATA_W-1:0] o_tx_data;
  logic              o_tx_en;

  modport master (
    output o_write_data, o_write_address, o_write_en, o_read_address,
    output o_tx_data, o_tx_en,
    input  i_read_data, i_tx_ready
  );

  modport slave (
    input  o_write_data, o_write_address, o_write_en, o_read_address,
    input  o_tx_data, o_tx_en,
    output i_read_data, i_tx_ready
  );

endinterface

// File: rtl/capture_controller_trigger_match.sv
// -----------------------------------------------------------------------------
// trigger_match
// Masked trigger compare for the capture controller.
//   match = ((sample ^ value) & mask) == 0
// Build option CAPTURE_EDGE_TRIG_EN: when defined, fire only when the current
// sample matches and the previous captured sample did not; a history flag is
// kept and cleared when a new capture starts. When undefined, fire on match
// (level trigger) and no history register exists.
// Ports:
//   i_clk, i_rst  clock / synchronous active-high reset (edge build only)
//   clear_i       new capture starting, forget history (edge build only)
//   update_i      current sample is being captured (edge build only)
//   sample_i      sample under test
//   mask_i        bits taking part in the compare
//   value_i       compare value
//   fire_o        trigger condition for the current sample
// -----------------------------------------------------------------------------
module trigger_match
  import la_pkg::*;
#(
  parameter int DATA_W = LA_DATA_W
) (
`ifdef CAPTURE_EDGE_TRIG_EN
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              clear_i,
  input  logic              update_i,
`endif
  input  logic [DATA_W-1:0] sample_i,
  input  logic [DATA_W-1:0] mask_i,
  input  logic [DATA_W-1:0] value_i,
  output logic              fire_o
);

  logic match;

  assign match = ((sample_i ^ value_i) & mask_i) == '0;

`ifdef CAPTURE_EDGE_TRIG_EN
  logic prev_match_q;

  always_ff @(posedge i_clk) begin
    // NOTE: i_rst is tested inside the clocked block, so reset is synchronous
    // and only takes effect on an i_clk edge.
    if (i_rst) begin
      prev_match_q <= 1'b0;
    end else if (clear_i) begin
      prev_match_q <= 1'b0;
    end else if (update_i) begin
      // NOTE: non-blocking assignment so every register in the design sees
      // the pre-edge value of every other register.
      prev_match_q <= match;
    end
  end

  assign fire_o = match & ~prev_match_q;
`else
  assign fire_o = match;
`endif

endmodule

// File: rtl/capture_controller.sv
// -----------------------------------------------------------------------------
// capture_controller
// Sequenced capture/readout controller for the logic analyzer. Samples are
// taken on i_sample_tick into a circular capture RAM with a pretrigger
// window; once the masked trigger fires and the post-trigger part of the
// buffer is filled, the buffer is streamed oldest-first to the UART.
// Build option CAPTURE_EDGE_TRIG_EN selects an edge trigger (see
// trigger_match); undefined gives a level trigger.
// Parameters: DATA_W sample width, ADDR_W RAM address width
// (DEPTH = 2**ADDR_W), PRE_TRIG samples kept before the trigger (0..DEPTH-1).
// Ports:
//   i_clk, i_rst    clock / synchronous active-high reset
//   i_sample_tick   one-cycle sample strobe
//   i_sample_data   probe inputs
//   i_arm           start-capture pulse (ignored while busy)
//   i_trig_mask     trigger compare mask
//   i_trig_value    trigger compare value
//   bus             RAM write/read ports and UART handshake (master)
//   o_busy          high in every state except IDLE/DONE
//   o_done          high in DONE
// -----------------------------------------------------------------------------
module capture_controller
  import la_pkg::*;
#(
  parameter int DATA_W   = LA_DATA_W,
  parameter int ADDR_W   = LA_ADDR_W,
  parameter int PRE_TRIG = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_sample_tick,
  input  logic [DATA_W-1:0]    i_sample_data,
  input  logic                 i_arm,
  input  logic [DATA_W-1:0]    i_trig_mask,
  input  logic [DATA_W-1:0]    i_trig_value,
  capture_controller_if.master bus,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int DEPTH = 1 << ADDR_W;

  if (PRE_TRIG < 0 || PRE_TRIG > DEPTH - 1) begin : g_bad_pre_trig
    $error("capture_controller: PRE_TRIG must lie in 0..DEPTH-1");
  end

  localparam logic [ADDR_W-1:0] PRE_A   = ADDR_W'(PRE_TRIG);
  localparam logic [ADDR_W-1:0] POST_N  = ADDR_W'(DEPTH - PRE_TRIG - 1);
  localparam logic [ADDR_W-1:0] LAST_W  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  la_state_t         state_q,      state_d;
  logic [ADDR_W-1:0] wptr_q,       wptr_d;
  logic [ADDR_W-1:0] cnt_q,        cnt_d;    // pretrigger up-count / post down-count
  logic [ADDR_W-1:0] raddr_q,      raddr_d;
  logic [ADDR_W-1:0] xcnt_q,       xcnt_d;   // words sent so far
  logic              write_en_q,   write_en_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic [ADDR_W-1:0] write_addr_q, write_addr_d;
  logic              tx_en_q,      tx_en_d;
  logic [DATA_W-1:0] tx_data_q,    tx_data_d;

  logic capture;     // current tick is written to the RAM
  logic arm_accept;  // i_arm seen in a resting state
  logic fire;

  assign arm_accept = i_arm && !la_is_busy(state_q);

  trigger_match #(
    .DATA_W   (DATA_W)
  ) u_trigger_match (
`ifdef CAPTURE_EDGE_TRIG_EN
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .clear_i  (arm_accept),
    .update_i (capture),
`endif
    .sample_i (i_sample_data),
    .mask_i   (i_trig_mask),
    .value_i  (i_trig_value),
    .fire_o   (fire)
  );

  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that left
    // one unassigned would infer a latch.
    state_d      = state_q;
    wptr_d       = wptr_q;
    cnt_d        = cnt_q;
    raddr_d      = raddr_q;
    xcnt_d       = xcnt_q;
    tx_en_d      = 1'b0;
    tx_data_d    = tx_data_q;
    capture      = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_arm) begin
          state_d = (PRE_TRIG == 0) ? ST_ARMED : ST_PRE;
          wptr_d  = '0;
          cnt_d   = '0;
        end
      end
      ST_PRE: begin
        if (i_sample_tick) begin
          capture = 1'b1;
          cnt_d   = cnt_q + ONE_A;
          if (cnt_q + ONE_A == PRE_A) state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (i_sample_tick) begin
          capture = 1'b1;
          if (fire) begin
            // The read start is fixed here: PRE_TRIG words before the trigger
            // sample's address, modulo DEPTH.
            raddr_d = wptr_q - PRE_A;
            cnt_d   = POST_N;
            state_d = ST_POST;
          end
        end
      end
      ST_POST: begin
        // cnt_q == 0 is the cycle the final registered write retires, so the
        // RAM write strobe never overlaps the transfer. A zero post count from
        // ARMED passes through here for that one cycle only.
        if (cnt_q == '0) begin
          xcnt_d  = '0;
          state_d = ST_XFER_RD;
        end else if (i_sample_tick) begin
          capture = 1'b1;
          cnt_d   = cnt_q - ONE_A;
        end
      end
      ST_XFER_RD:   state_d = ST_XFER_WAIT;
      ST_XFER_WAIT: state_d = ST_XFER_SEND;
      ST_XFER_SEND: begin
        // The read address has been stable since XFER_RD, so i_read_data is
        // valid here for a 1-cycle registered RAM.
        if (bus.i_tx_ready) begin
          tx_data_d = bus.i_read_data;
          tx_en_d   = 1'b1;
          state_d   = ST_XFER_GAP;
        end
      end
      ST_XFER_GAP: begin
        raddr_d = raddr_q + ONE_A;
        xcnt_d  = xcnt_q + ONE_A;
        state_d = (xcnt_q == LAST_W) ? ST_DONE : ST_XFER_RD;
      end
      default: state_d = ST_IDLE;
    endcase

    if (capture) wptr_d = wptr_q + ONE_A;

    // Write port is registered: a tick shows up as a write on the next cycle,
    // and a tick in that same cycle is captured independently.
    write_en_d   = capture;
    write_data_d = capture ? i_sample_data : write_data_q;
    write_addr_d = capture ? wptr_q        : write_addr_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      wptr_q       <= '0;
      cnt_q        <= '0;
      raddr_q      <= '0;
      xcnt_q       <= '0;
      write_en_q   <= 1'b0;
      write_data_q <= '0;
      write_addr_q <= '0;
      tx_en_q      <= 1'b0;
      tx_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      cnt_q        <= cnt_d;
      raddr_q      <= raddr_d;
      xcnt_q       <= xcnt_d;
      write_en_q   <= write_en_d;
      write_data_q <= write_data_d;
      write_addr_q <= write_addr_d;
      tx_en_q      <= tx_en_d;
      tx_data_q    <= tx_data_d;
    end
  end

  assign bus.o_write_en      = write_en_q;
  assign bus.o_write_data    = write_data_q;
  assign bus.o_write_address = write_addr_q;
  assign bus.o_read_address  = raddr_q;
  assign bus.o_tx_en         = tx_en_q;
  assign bus.o_tx_data       = tx_data_q;
  assign o_busy              = la_is_busy(state_q);
  assign o_done              = (state_q == ST_DONE);

endmodule

// File: tb/tb_capture_controller.sv
// -----------------------------------------------------------------------------
// tb_capture_controller
// Self-checking bench for capture_controller with DATA_W=12, ADDR_W=4,
// PRE_TRIG=4. A behavioural RAM and UART sit on the interface; the expected
// buffer contents come from the list of ticked samples: find the first
// trigger index k at or after PRE_TRIG, then the RAM sees k+DEPTH-PRE_TRIG
// writes and the UART receives samples k-PRE_TRIG .. k-PRE_TRIG+DEPTH-1.
// Honours CAPTURE_EDGE_TRIG_EN for the trigger rule.
// -----------------------------------------------------------------------------
module tb_capture_controller;
  import la_pkg::*;

  localparam int DATA_W   = 12;
  localparam int ADDR_W   = 4;
  localparam int DEPTH    = 16;
  localparam int PRE_TRIG = 4;
  localparam int MAX_CYC  = 4000;

  logic              clk = 1'b0;
  logic              rst;
  logic              tick;
  logic              arm;
  logic [DATA_W-1:0] sample;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] value;
  logic              busy;
  logic              done;

  capture_controller_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  capture_controller #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .PRE_TRIG (PRE_TRIG)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_sample_tick (tick),
    .i_sample_data (sample),
    .i_arm         (arm),
    .i_trig_mask   (mask),
    .i_trig_value  (value),
    .bus           (bus),
    .o_busy        (busy),
    .o_done        (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Capture RAM with 1-cycle registered read.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.o_write_en) mem[bus.o_write_address] <= bus.o_write_data;
    bus.i_read_data <= mem[bus.o_read_address];
  end

  // Monitor + UART model.
  int  wa_q[$];
  int  wd_q[$];
  int  rx_q[$];
  int  hold      = 0;
  int  bp_data   = 0;
  bit  bp_arm    = 1'b0;
  bit  bp_check  = 1'b0;
  bit  last_rdy  = 1'b1;
  bit  prev_txen = 1'b0;

  always @(negedge clk) begin
    if (bus.o_write_en) begin
      wa_q.push_back(int'(bus.o_write_address));
      wd_q.push_back(int'(bus.o_write_data));
    end
    if (prev_txen) check("tx_gap", bus.o_tx_en, 0);
    if (bus.o_tx_en) check("tx_while_not_ready", last_rdy, 1);
    if (bp_check) begin
      if (hold > 0) begin
        check("bp_no_pulse", bus.o_tx_en, 0);
        check("bp_data_stable", bus.o_tx_data, bp_data);
      end else begin
        bp_check = 1'b0;
      end
    end
    if (bus.o_tx_en) begin
      rx_q.push_back(int'(bus.o_tx_data));
      if (bp_arm && rx_q.size() == 3) begin
        hold     = 20;
        bp_arm   = 1'b0;
        bp_check = 1'b1;
        bp_data  = int'(bus.o_tx_data);
      end else begin
        hold = $urandom_range(0, 2);
      end
    end
    prev_txen = bus.o_tx_en;
    if (hold > 0) begin
      bus.i_tx_ready = 1'b0;
      hold--;
    end else begin
      bus.i_tx_ready = 1'b1;
    end
    last_rdy = bus.i_tx_ready;
  end

  // Reference model over the ticked sample list.
  logic [DATA_W-1:0] smp_q[$];

  function automatic bit hit(input int j);
    return ((smp_q[j] ^ value) & mask) == '0;
  endfunction

  function automatic bit fires(input int j);
`ifdef CAPTURE_EDGE_TRIG_EN
    return hit(j) && !(j > 0 && hit(j - 1));
`else
    return hit(j);
`endif
  endfunction

  task automatic check_quiet(input string pfx);
    check({pfx, "_write_en"},   bus.o_write_en, 0);
    check({pfx, "_write_addr"}, bus.o_write_address, 0);
    check({pfx, "_write_data"}, bus.o_write_data, 0);
    check({pfx, "_read_addr"},  bus.o_read_address, 0);
    check({pfx, "_tx_en"},      bus.o_tx_en, 0);
    check({pfx, "_tx_data"},    bus.o_tx_data, 0);
    check({pfx, "_busy"},       busy, 0);
    check({pfx, "_done"},       done, 0);
  endtask

  task automatic fill_count(input int base);
    smp_q.delete();
    for (int i = 0; i < 256; i++) smp_q.push_back(DATA_W'(base + i));
  endtask

  task automatic fill_random();
    smp_q.delete();
    for (int i = 0; i < 256; i++) smp_q.push_back(DATA_W'($urandom_range(0, 4095)));
  endtask

  // One full capture + readout; called at a negedge.
  task automatic session(input logic [DATA_W-1:0] m, input logic [DATA_W-1:0] v,
                         input bit arm_tick, input bit stray_arm, input bit bp);
    int idx = 0;
    int cyc = 0;
    int k   = -1;
    mask = m;
    value = v;
    wa_q.delete();
    wd_q.delete();
    rx_q.delete();
    bp_arm = bp;
    arm    = 1'b1;
    tick   = arm_tick;       // a tick alongside arm must not be captured
    sample = 12'h800;
    @(negedge clk);
    arm  = 1'b0;
    tick = 1'b0;
    check("busy_after_arm", busy, 1);
    while (!done && cyc < MAX_CYC) begin
      tick = 1'b0;
      if (idx < smp_q.size() && $urandom_range(0, 1) == 1) begin
        tick   = 1'b1;
        sample = smp_q[idx];
        idx++;
      end
      arm = stray_arm && busy && ($urandom_range(0, 3) == 0);
      @(negedge clk);
      cyc++;
    end
    tick = 1'b0;
    arm  = 1'b0;
    check("session_in_time", int'(cyc < MAX_CYC), 1);
    for (int j = PRE_TRIG; j < idx && k < 0; j++) if (fires(j)) k = j;
    check("trigger_found", int'(k >= 0), 1);
    if (k >= 0) begin
      check("write_count", wa_q.size(), k + DEPTH - PRE_TRIG);
      for (int i = 0; i < wa_q.size() && i < idx; i++) begin
        check("write_addr", wa_q[i], i % DEPTH);
        check("write_data", wd_q[i], int'(smp_q[i]));
      end
      check("tx_count", rx_q.size(), DEPTH);
      for (int i = 0; i < rx_q.size() && k - PRE_TRIG + i < idx; i++)
        check("tx_word", rx_q[i], int'(smp_q[k - PRE_TRIG + i]));
    end
    check("done_set", done, 1);
    check("busy_clear", busy, 0);
    repeat (3) @(negedge clk);
    check("done_held", done, 1);
  endtask

  initial begin
    int n;
    rst    = 1'b1;
    tick   = 1'b0;
    arm    = 1'b0;
    sample = '0;
    mask   = '0;
    value  = '0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of POST aborts the capture.
    fill_count(0);
    mask  = 12'hFFF;
    value = 12'h00A;
    arm   = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick   = 1'b1;
      sample = smp_q[i];
      @(negedge clk);
    end
    tick = 1'b0;
    check("mid_post_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_quiet("mid_post_rst");
    n = wa_q.size();
    for (int i = 0; i < 12; i++) begin
      tick   = 1'b1;
      sample = DATA_W'(i);
      @(negedge clk);
    end
    tick = 1'b0;
    check("idle_ticks_no_write", wa_q.size(), n);
    check("idle_after_rst", busy, 0);

    // Basic capture: trigger at address 10, sends 0x006..0x015.
    fill_count(0);
    session(12'hFFF, 12'h00A, 1'b1, 1'b0, 1'b0);
    if (rx_q.size() == DEPTH) begin
      check("basic_first", rx_q[0], 'h006);
      check("basic_last", rx_q[DEPTH-1], 'h015);
    end

    // Wrapped trigger address: sends 0x01A..0x029.
    fill_count(0);
    session(12'hFFF, 12'h01E, 1'b0, 1'b0, 1'b0);
    if (rx_q.size() == DEPTH) begin
      check("wrap_first", rx_q[0], 'h01A);
      check("wrap_last", rx_q[DEPTH-1], 'h029);
    end

`ifndef CAPTURE_EDGE_TRIG_EN
    // Mask 0: first ARMED sample triggers, first word is sample 0.
    fill_count(0);
    session(12'h000, 12'h5A5, 1'b1, 1'b0, 1'b0);
    if (rx_q.size() == DEPTH) check("mask0_first", rx_q[0], 'h000);
`endif

    // Trigger value already present before arm, then gone, then back.
    smp_q.delete();
    for (int i = 0; i < 10; i++) smp_q.push_back(12'h5A5);
    for (int i = 0; i < 3; i++) smp_q.push_back(DATA_W'(i));
    smp_q.push_back(12'h5A5);
    for (int i = 0; i < 200; i++) smp_q.push_back(DATA_W'(12'h100 + i));
    session(12'hFFF, 12'h5A5, 1'b0, 1'b1, 1'b0);

    // UART backpressure with stray arm pulses while busy.
    fill_random();
    session(12'h003, 12'h002, 1'b0, 1'b1, 1'b1);

    // Randomised sessions.
    for (int s = 0; s < 6; s++) begin
      logic [DATA_W-1:0] m;
      m = DATA_W'((1 << $urandom_range(0, 11)) | (1 << $urandom_range(0, 11)));
      fill_random();
      session(m, DATA_W'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/capture_controller.md
Name: capture_controller

Overview:
Parametrised capture/readout controller for the logic analyzer; it replaces the single-clock-pair sample latch with a fully sequenced controller. It runs on `i_clk` only and takes samples on a one-cycle `i_sample_tick` strobe produced by the sample-rate divider. It writes a circular capture RAM with a pretrigger window and evaluates a masked trigger. After capture it streams the buffer, oldest sample first, to the UART transmitter.

Parameters:
- DATA_W, 12, sample width in bits.
- ADDR_W, 9, capture RAM address width; DEPTH = 2^ADDR_W.
- PRE_TRIG, 64, samples retained before the trigger; legal range 0..DEPTH-1, checked at elaboration.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous active-high reset.
- i_sample_tick  in  1  one-cycle sample strobe, i_clk domain.
- i_sample_data  in  DATA_W  probe inputs, already synchronised.
- i_arm  in  1  start capture pulse.
- i_trig_mask  in  DATA_W  bits included in trigger compare.
- i_trig_value  in  DATA_W  trigger compare value.
- o_write_data  out  DATA_W  RAM write data.
- o_write_address  out  ADDR_W  RAM write address.
- o_write_en  out  1  RAM write strobe.
- o_read_address  out  ADDR_W  RAM read address.
- i_read_data  in  DATA_W  RAM read data, 1-cycle registered latency.
- i_tx_ready  in  1  UART idle.
- o_tx_data  out  DATA_W  word to UART.
- o_tx_en  out  1  one-cycle send pulse.
- o_busy  out  1  high in any state except IDLE/DONE.
- o_done  out  1  high in DONE.

Behaviour:
- Reset: synchronous and active-high. On `i_rst` the FSM goes to IDLE, all counters clear, and every output is 0. `i_rst` mid-operation aborts immediately; there is no partial transfer.
- Write path: on each `i_sample_tick` in PRE/ARMED/POST, the next cycle has `o_write_en`=1, `o_write_data`=sample, and `o_write_address`=wptr. wptr then increments mod DEPTH.
- Trigger (level mode): match = ((sample ^ i_trig_value) & i_trig_mask) == 0. A mask of 0 means the first ARMED sample triggers.
- IDLE: on `i_arm` go to PRE; wptr=0 and the pretrigger count pc=0.
- PRE: each tick writes and increments pc. The trigger is ignored. When pc==PRE_TRIG go to ARMED; with PRE_TRIG=0, go to ARMED directly from IDLE.
- ARMED: every tick writes, with wptr wrapping. On the first matching sample, latch taddr = that sample's address, set post count = DEPTH-PRE_TRIG-1, and go to POST. If that count is 0, go straight to XFER.
- POST: each tick writes and decrements the count. After the write with count==0, go to XFER.
- Buffer contents: exactly PRE_TRIG samples precede the trigger sample and the buffer holds DEPTH samples in total.
- XFER: raddr starts at (taddr - PRE_TRIG) mod DEPTH and runs for DEPTH words. Each word uses this sub-sequence:
  - RD: drive `o_read_address`.
  - WAIT: data valid on the next cycle.
  - SEND: wait for `i_tx_ready`=1, then load `o_tx_data` and pulse `o_tx_en` for 1 cycle.
  - GAP: 1-cycle holdoff so the UART can drop ready.
- XFER exit: after the DEPTH-th send, go to DONE.
- DONE: `o_done`=1, held until `i_arm`, which re-enters PRE.
- Simultaneous and unexpected events:
  - `i_arm` is ignored while `o_busy`.
  - `i_arm` and `i_sample_tick` in the same cycle in IDLE/DONE: the state changes and that sample is not captured.
  - `i_sample_tick` in IDLE/XFER/DONE is dropped; `o_write_en` is never high in XFER.
  - A tick arriving in the cycle a write is issued is still captured, because the write path is registered each cycle.

Optional Feature:
- CAPTURE_EDGE_TRIG_EN defined: the trigger requires match on the current sample AND no match on the previous captured sample. The previous-match flag clears on entry to PRE, so the first ARMED sample cannot fire on a level already present in PRE.
- CAPTURE_EDGE_TRIG_EN undefined: level trigger as above; no history register.

Decomposition:
- Shared package `la_pkg`:
  - FSM state encoding: IDLE, PRE, ARMED, POST, XFER_RD, XFER_WAIT, XFER_SEND, XFER_GAP, DONE.
  - Default DATA_W/ADDR_W constants, reused by the capture RAM and UART framing.
- Sub-module `trigger_match`: compare plus the optional edge history register; everything else stays in `capture_controller`.

Test Plan (ADDR_W=4, DEPTH=16, PRE_TRIG=4, DATA_W=12):
- Reset mid-POST: assert `i_rst` 1 cycle -> next cycle state IDLE, all outputs 0, and no further `o_write_en`.
- Basic capture: arm; ticks carry samples 0x000,0x001,...; trigger mask 0xFFF, value 0x00A -> trigger at address 10. Transfer sends 0x006..0x015 in order: 16 `o_tx_en` pulses, then `o_done`=1.
- Wrap: value 0x01E with samples counting from 0 -> taddr wraps, start raddr = (taddr-4) mod 16. The transmitted sequence is 0x01A..0x029, contiguous.
- Mask 0 -> first ARMED sample (5th tick) triggers; 16 words are sent, first word = sample 0.
- UART backpressure: hold `i_tx_ready`=0 for 20 cycles during XFER -> no `o_tx_en`, `o_tx_data` stable. Release -> exactly one pulse, then at least 1 gap cycle.
- `i_arm` pulsed during ARMED and XFER -> no state change. With CAPTURE_EDGE_TRIG_EN defined and value present before arm -> no trigger until the value goes away and returns.
